// File: rtl/ama_riscv_dmem_arb.sv
// ----------------------------------------------------------------------------
// ama_riscv_dmem_arb
//   Arbitrates the single dcache request port between the core LSU
//   (requester 0) and an auxiliary master (requester 1). Load responses come
//   back in order and are routed to the requester that issued the load.
//
//   Requester 0 has priority. Requester 1 is promoted after waiting
//   STARVE_MAX consecutive cycles. A request stalled by the dcache keeps its
//   grant until it transfers. Loads are held back while the response ID FIFO
//   is full; stores are never held back by it.
//
// Parameters
//   ARCH_WIDTH  address/data width
//   MAX_OUTST   max outstanding loads (ID FIFO depth, power of 2, >=1)
//   STARVE_MAX  wait cycles before requester 1 is promoted (>=1)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   rN_req_*                 requester N: valid/ready/addr/wdata/dtype/rtype
//                            (rtype 1=store, 0=load; dtype 0=b,1=h,2=w)
//   m_req_*                  muxed request towards the dcache
//   m_rsp_valid/m_rsp_data   in-order dcache load response
//   rN_rsp_valid             routed response strobes
//   rsp_data                 shared response data (m_rsp_data passthrough)
//   err_rsp_unexp            sticky: response seen with empty ID FIFO
//
// Optional build macro DMEM_ARB_STATS_EN adds saturating counters
//   stat_gnt0/stat_gnt1 (transfers per requester) and stat_stall (cycles
//   with any request valid and no transfer).
// ----------------------------------------------------------------------------
module ama_riscv_dmem_arb #(
  parameter int ARCH_WIDTH = 32,
  parameter int MAX_OUTST  = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_req_valid,
  output logic                  r0_req_ready,
  input  logic [ARCH_WIDTH-1:0] r0_req_addr,
  input  logic [ARCH_WIDTH-1:0] r0_req_wdata,
  input  logic [1:0]            r0_req_dtype,
  input  logic                  r0_req_rtype,
  input  logic                  r1_req_valid,
  output logic                  r1_req_ready,
  input  logic [ARCH_WIDTH-1:0] r1_req_addr,
  input  logic [ARCH_WIDTH-1:0] r1_req_wdata,
  input  logic [1:0]            r1_req_dtype,
  input  logic                  r1_req_rtype,
  output logic                  m_req_valid,
  input  logic                  m_req_ready,
  output logic [ARCH_WIDTH-1:0] m_req_addr,
  output logic [ARCH_WIDTH-1:0] m_req_wdata,
  output logic [1:0]            m_req_dtype,
  output logic                  m_req_rtype,
  input  logic                  m_rsp_valid,
  input  logic [ARCH_WIDTH-1:0] m_rsp_data,
  output logic                  r0_rsp_valid,
  output logic                  r1_rsp_valid,
  output logic [ARCH_WIDTH-1:0] rsp_data,
  output logic                  err_rsp_unexp
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]           stat_gnt0,
  output logic [31:0]           stat_gnt1,
  output logic [31:0]           stat_stall
`endif
);

  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int AGE_W = $clog2(STARVE_MAX + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTST - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTST);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_MAX);

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  req_id_t          gnt_id;
  logic             gnt_valid;
  logic             lock_q;
  req_id_t          owner_q;
  logic [AGE_W-1:0] age_cnt;

  req_id_t          id_mem [MAX_OUTST];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_empty;
  logic             fifo_full;
  req_id_t          fifo_head;

  logic             r0_elig;
  logic             r1_elig;
  logic             xfer;
  logic             r1_xfer;
  logic             push;
  logic             pop;
  logic             err_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CNT_FULL);
  assign fifo_head  = id_mem[rd_ptr];

  // Full check uses the registered count only, so a same-cycle pop never
  // unblocks a load and m_rsp_valid has no path to m_req_valid.
  assign r0_elig = r0_req_valid && (r0_req_rtype || !fifo_full);
  assign r1_elig = r1_req_valid && (r1_req_rtype || !fifo_full);

  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = REQ0;
    if (!rst) begin
      if (lock_q) begin
        gnt_id    = owner_q;
        gnt_valid = (owner_q == REQ1) ? r1_elig : r0_elig;
      end else if (r1_elig && (age_cnt >= AGE_MAX)) begin
        gnt_valid = 1'b1;
        gnt_id    = REQ1;
      end else if (r0_elig) begin
        gnt_valid = 1'b1;
        gnt_id    = REQ0;
      end else if (r1_elig) begin
        gnt_valid = 1'b1;
        gnt_id    = REQ1;
      end
    end
  end

  always_comb begin
    m_req_addr  = '0;
    m_req_wdata = '0;
    m_req_dtype = '0;
    m_req_rtype = 1'b0;
    if (gnt_valid) begin
      if (gnt_id == REQ1) begin
        m_req_addr  = r1_req_addr;
        m_req_wdata = r1_req_wdata;
        m_req_dtype = r1_req_dtype;
        m_req_rtype = r1_req_rtype;
      end else begin
        m_req_addr  = r0_req_addr;
        m_req_wdata = r0_req_wdata;
        m_req_dtype = r0_req_dtype;
        m_req_rtype = r0_req_rtype;
      end
    end
  end

  assign m_req_valid  = gnt_valid;
  assign xfer         = gnt_valid && m_req_ready;
  assign r1_xfer      = xfer && (gnt_id == REQ1);
  assign r0_req_ready = xfer && (gnt_id == REQ0);
  assign r1_req_ready = r1_xfer;

  assign push = xfer && !m_req_rtype;
  assign pop  = m_rsp_valid && !fifo_empty && !rst;

  assign r0_rsp_valid  = pop && (fifo_head == REQ0);
  assign r1_rsp_valid  = pop && (fifo_head == REQ1);
  assign rsp_data      = m_rsp_data;
  assign err_rsp_unexp = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q   <= 1'b0;
      owner_q  <= REQ0;
      age_cnt  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      // Lock is held exactly while a presented request is stalled; it drops
      // on the transfer cycle.
      lock_q <= gnt_valid && !m_req_ready;
      if (gnt_valid) owner_q <= gnt_id;

      if (r1_req_valid && !r1_xfer) begin
        if (age_cnt != AGE_MAX) age_cnt <= age_cnt + 1'b1;
      end else begin
        age_cnt <= '0;
      end

      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!push && pop) fifo_cnt <= fifo_cnt - 1'b1;

      if (m_rsp_valid && fifo_empty) err_q <= 1'b1;
    end
  end

  // ID storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr] <= gnt_id;
  end

`ifdef DMEM_ARB_STATS_EN
  logic stall;
  assign stall = (r0_req_valid || r1_req_valid) && !xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_gnt0  <= '0;
      stat_gnt1  <= '0;
      stat_stall <= '0;
    end else begin
      if (r0_req_ready && (stat_gnt0 != '1))  stat_gnt0  <= stat_gnt0 + 1'b1;
      if (r1_xfer && (stat_gnt1 != '1))       stat_gnt1  <= stat_gnt1 + 1'b1;
      if (stall && (stat_stall != '1))        stat_stall <= stat_stall + 1'b1;
    end
  end
`endif

endmodule

// File: doc/ama_riscv_dmem_arb.md
Name: ama_riscv_dmem_arb

Overview:
- Arbitrates the single data-cache request port between two requesters: requester 0 (core LSU, exe stage) and requester 1 (auxiliary master, e.g. tohost/debug loader).
- Routes in-order load responses back to the requester that issued them.
- Sits between the core/aux masters and the dcache.
- Core has priority; an aging counter guarantees requester 1 forward progress.

Parameters:
- ARCH_WIDTH, 32, address/data width
- MAX_OUTST, 2, max outstanding loads (depth of the response-routing ID FIFO, power of 2, >=1)
- STARVE_MAX, 4, consecutive cycles requester 1 may wait while requester 0 wins before it is promoted (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- r0_req_valid  in  1  core request valid
- r0_req_ready  out  1  core request accepted this cycle
- r0_req_addr  in  ARCH_WIDTH  core address
- r0_req_wdata  in  ARCH_WIDTH  core store data
- r0_req_dtype  in  2  access size (0=b,1=h,2=w)
- r0_req_rtype  in  1  1=store, 0=load
- r1_req_valid/ready/addr/wdata/dtype/rtype  same as r0_*  auxiliary requester
- m_req_valid  out  1  request to dcache
- m_req_ready  in  1  dcache accepts
- m_req_addr, m_req_wdata  out  ARCH_WIDTH  muxed request fields
- m_req_dtype  out  2; m_req_rtype  out  1
- m_rsp_valid  in  1  dcache load response (one per accepted load, in order)
- m_rsp_data  in  ARCH_WIDTH  load data
- r0_rsp_valid, r1_rsp_valid  out  1  routed response strobes
- rsp_data  out  ARCH_WIDTH  shared response data (m_rsp_data passthrough)
- err_rsp_unexp  out  1  sticky: m_rsp_valid with empty ID FIFO

Behaviour:
- Reset: lock cleared, owner=0, aging counter=0, ID FIFO empty, err_rsp_unexp=0. All outputs 0 except m_req_* data fields (don't-care, driven 0).
- Handshake: transfer when m_req_valid && m_req_ready. rN_req_ready = m_req_ready && granted==N && !fifo_block. Requesters hold their fields stable until ready.
- Grant, when not locked:
  - Promotion: requester 1 wins if it is valid and age_cnt>=STARVE_MAX.
  - Otherwise requester 0 wins if valid; else requester 1 if valid; else idle (m_req_valid=0).
- Lock: if m_req_valid=1 and m_req_ready=0, lock=1 with owner=current grant. While locked, the grant stays with the owner regardless of the other requester. Lock clears on transfer.
- Aging: age_cnt increments (saturating at STARVE_MAX) each cycle r1_req_valid=1 and requester 1 does not transfer. It clears on requester 1 transfer or r1_req_valid=0.
- fifo_block: a load is not presented (m_req_valid=0, rN_req_ready=0) when the ID FIFO holds MAX_OUTST entries. This applies even if m_rsp_valid pops in the same cycle. Stores are never blocked by the FIFO.
- ID FIFO:
  - Push the granted ID on every load transfer; stores do not push.
  - Pop on m_rsp_valid.
  - Simultaneous push/pop is allowed when not full; count is unchanged.
  - Pointers wrap modulo MAX_OUTST.
- Response routing, combinational, 0 latency: rN_rsp_valid = m_rsp_valid && fifo_head==N && !fifo_empty. rsp_data = m_rsp_data.
- Unexpected response: m_rsp_valid with an empty FIFO is dropped (no rN_rsp_valid), err_rsp_unexp<=1 sticky until rst.
- Reset mid-operation: all in-flight IDs are discarded. Later stray responses are dropped and set err_rsp_unexp.
- No combinational path from m_rsp_valid to m_req_valid.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined: adds outputs stat_gnt0, stat_gnt1 (32b, transfers per requester) and stat_stall (32b, cycles with any rN_req_valid=1 and no transfer). All three are saturating, cleared on rst, and increment one cycle after the event.
- Undefined: ports and counters absent; functional behaviour identical.

Test Plan:
- Core load only, r0 addr=0x100, m_req_ready=1, response 2 cycles later data=0xDEADBEEF -> r0_req_ready=1 same cycle; r0_rsp_valid=1 with rsp_data=0xDEADBEEF; r1_rsp_valid=0.
- Both valid continuously, all ready, STARVE_MAX=4 -> grant sequence 0,0,0,0,1,0,0,0,0,1; age_cnt resets after each r1 transfer.
- r1 granted, m_req_ready=0 for 3 cycles, r0 raises valid at cycle 1 -> m_req_addr stays r1's address all 3 cycles; r1 transfers on cycle 4; r0 transfers cycle 5.
- MAX_OUTST=2: two loads accepted, no responses, third load pending -> m_req_valid=0. A store from r1 still transfers. On first m_rsp_valid -> r0 response; third load accepted the next cycle.
- Interleaved loads r0,r1,r0 with in-order responses D0,D1,D2 -> r0_rsp_valid, r1_rsp_valid, r0_rsp_valid in that order with matching data.
- rst asserted with 2 loads outstanding, then m_rsp_valid pulses -> no rN_rsp_valid; err_rsp_unexp=1 and stays 1.
